// File: rtl/synth_pkg.sv
// Shared synth-voice types, widths and the waveform shaper used by oscillator/LFO blocks.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW     = 2'd0,
    WAVE_SQUARE  = 2'd1,
    WAVE_TRI     = 2'd2,
    WAVE_SILENCE = 2'd3
  } wave_t;

  localparam int SAMPLE_W = 11;
  localparam int SUM_W    = SAMPLE_W + 1;

  // msb is the phase MSB; t is the top SAMPLE_W phase bits, u the SAMPLE_W bits just below the MSB.
  function automatic logic [SAMPLE_W-1:0] shape(
    input wave_t               sel,
    input logic                msb,
    input logic [SAMPLE_W-1:0] t,
    input logic [SAMPLE_W-1:0] u
  );
    logic [SAMPLE_W-1:0] res;
    res = '0;
    case (sel)
      WAVE_SAW:    res = t;
      WAVE_SQUARE: res = msb ? {SAMPLE_W{1'b1}} : {SAMPLE_W{1'b0}};
      WAVE_TRI:    res = msb ? ~u : u;
      default:     res = SAMPLE_W'(1) << (SAMPLE_W - 1);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wave_oscillator_tick_divider.sv
// Enable-gated clock divider: one-cycle combinational tick every DIV enabled cycles.
// Latency: tick is asserted during the last count cycle; ena low holds the count, no backpressure.
module tick_divider #(
  parameter int DIV = 2083
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = ena && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (ena) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wave_oscillator.sv
// NCO voice: phase accumulator + shaper, one sample per divider tick; frequency swaps only at a phase wrap.
// Latency: sample/valid/wrap register one cycle after the tick cycle; no backpressure, ena low freezes everything.
module wave_oscillator #(
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 11,
  parameter int CLK_DIV  = 2083
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [PHASE_W-1:0]  freq_word,
  input  logic                freq_load,
  input  logic [1:0]          wave_sel,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                wrap
);

  import synth_pkg::*;

  logic                tick;
  logic [PHASE_W:0]    sum;
  logic                carry;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PHASE_W-1:0]  freq_cur_q, freq_cur_d;
  logic [PHASE_W-1:0]  pending_q, pending_d;
  logic                pend_v_q, pend_v_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;

  tick_divider #(.DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .tick (tick)
  );

  assign sum   = {1'b0, phase_q} + {1'b0, freq_cur_q};
  assign carry = sum[PHASE_W];

  always_comb begin
    phase_d    = phase_q;
    freq_cur_d = freq_cur_q;
    pending_d  = pending_q;
    pend_v_d   = pend_v_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    wrap_d     = 1'b0;
    if (tick) begin
      phase_d  = sum[PHASE_W-1:0];
      sample_d = shape(wave_t'(wave_sel), sum[PHASE_W-1],
                       sum[PHASE_W-1 -: SAMPLE_W], sum[PHASE_W-2 -: SAMPLE_W]);
      valid_d  = 1'b1;
      wrap_d   = carry;
      // A zero increment never wraps, so it must be allowed to pick up a new word directly.
      if (pend_v_q && (carry || (freq_cur_q == '0))) begin
        freq_cur_d = pending_q;
        pend_v_d   = 1'b0;
      end
    end
    // A coincident load lands after the apply so the new word stays pending.
    if (freq_load) begin
      pending_d = freq_word;
      pend_v_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q    <= '0;
      freq_cur_q <= '0;
      pending_q  <= '0;
      pend_v_q   <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      freq_cur_q <= freq_cur_d;
      pending_q  <= pending_d;
      pend_v_q   <= pend_v_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_wave_oscillator.sv
// Self-checking bench for wave_oscillator with a tick-level arithmetic reference model.
module tb_wave_oscillator;

  localparam int PW  = 12;
  localparam int SW  = 11;
  localparam int DIV = 4;
  localparam int PMOD = 1 << PW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b0;
  logic [PW-1:0] freq_word = '0;
  logic          freq_load = 1'b0;
  logic [1:0]    wave_sel = 2'd0;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          wrap;

  always #5 clk = ~clk;

  wave_oscillator #(.PHASE_W(PW), .SAMPLE_W(SW), .CLK_DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .freq_word    (freq_word),
    .freq_load    (freq_load),
    .wave_sel     (wave_sel),
    .sample       (sample),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state (plain integers).
  int m_div = 0, m_phase = 0, m_fcur = 0, m_pend = 0;
  bit m_pv = 0;
  int exp_sample = 0;
  bit exp_valid = 0, exp_wrap = 0;

  function automatic int ref_shape(input int s, input int p);
    case (s)
      0:       return p / 2;
      1:       return (p >= PMOD / 2) ? 2047 : 0;
      2:       return (p < PMOD / 2) ? p : (PMOD - 1 - p);
      default: return 1024;
    endcase
  endfunction

  function automatic bit wrap_next();
    return (m_div == DIV - 1) && (m_phase + m_fcur >= PMOD);
  endfunction

  // Drives one clock of inputs and advances the model; returns #1 after the edge.
  task automatic cycle(input bit r, input bit e, input bit ld, input int w, input int s);
    int  sum;
    bit  carry;
    rst = r; ena = e; freq_load = ld; freq_word = PW'(w); wave_sel = 2'(s);
    @(posedge clk);
    cyc++;
    if (!r) begin
      m_div = 0; m_phase = 0; m_fcur = 0; m_pend = 0; m_pv = 0;
      exp_sample = 0; exp_valid = 0; exp_wrap = 0;
    end else begin
      exp_valid = 0;
      exp_wrap  = 0;
      if (e && m_div == DIV - 1) begin
        sum        = m_phase + m_fcur;
        carry      = (sum >= PMOD);
        exp_valid  = 1;
        exp_wrap   = carry;
        exp_sample = ref_shape(s, sum % PMOD);
        if (m_pv && (carry || m_fcur == 0)) begin
          m_fcur = m_pend;
          m_pv   = 0;
        end
        m_phase = sum % PMOD;
      end
      if (e) m_div = (m_div + 1) % DIV;
      if (ld) begin
        m_pend = w;
        m_pv   = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (2) begin
      cycle(0, 1, 1, 123, 1);
      n_checks++;
      if (sample !== '0 || sample_valid !== 1'b0 || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: got s=%0d v=%0b w=%0b, want s=0 v=0 w=0", sample, sample_valid, wrap);
      end
    end
  endtask

  task automatic test_saw();
    int q[$];
    int vc[$];
    int wraps = 0;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 256, 0);
    repeat (DIV * 33) begin
      cycle(1, 1, 0, 0, 0);
      n_checks++;
      if (sample_valid !== exp_valid || wrap !== exp_wrap || sample !== SW'(exp_sample)) begin
        n_fail++;
        $display("FAIL saw_cycle%0d: got v=%0b w=%0b s=%0d, want v=%0b w=%0b s=%0d",
                 cyc, sample_valid, wrap, sample, exp_valid, exp_wrap, exp_sample);
      end
      if (sample_valid) begin
        q.push_back(int'(sample));
        vc.push_back(cyc);
      end
      if (wrap) wraps++;
    end
    n_checks++;
    if (q.size() != 33) begin
      n_fail++;
      $display("FAIL saw_count: got %0d samples, want 33", q.size());
    end else begin
      for (int k = 0; k <= 16; k++) begin
        int want;
        want = (k == 0 || k == 16) ? 0 : k * 128;
        n_checks++;
        if (q[k] != want) begin
          n_fail++;
          $display("FAIL saw_seq[%0d]: got %0d, want %0d", k, q[k], want);
        end
      end
      for (int i = 1; i < 33; i++) begin
        n_checks++;
        if (vc[i] - vc[i-1] != DIV) begin
          n_fail++;
          $display("FAIL saw_cadence[%0d]: got gap %0d, want %0d", i, vc[i] - vc[i-1], DIV);
        end
      end
    end
    n_checks++;
    if (wraps != 2) begin
      n_fail++;
      $display("FAIL saw_wraps: got %0d, want 2", wraps);
    end
  endtask

  task automatic test_square_tri();
    int q[$];
    int peak = 0;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 256, 1);
    repeat (DIV * 16) begin
      cycle(1, 1, 0, 0, 1);
      n_checks++;
      if (sample_valid !== exp_valid || wrap !== exp_wrap || sample !== SW'(exp_sample)) begin
        n_fail++;
        $display("FAIL square_cycle%0d: got v=%0b w=%0b s=%0d, want v=%0b w=%0b s=%0d",
                 cyc, sample_valid, wrap, sample, exp_valid, exp_wrap, exp_sample);
      end
      if (sample_valid) q.push_back(int'(sample));
    end
    n_checks++;
    if (q.size() != 16) begin
      n_fail++;
      $display("FAIL square_count: got %0d, want 16", q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (q[k] != ((k < 8) ? 0 : 2047)) begin
          n_fail++;
          $display("FAIL square_seq[%0d]: got %0d, want %0d", k, q[k], (k < 8) ? 0 : 2047);
        end
      end
    end
    repeat (DIV * 16) begin
      cycle(1, 1, 0, 0, 2);
      n_checks++;
      if (sample_valid !== exp_valid || wrap !== exp_wrap || sample !== SW'(exp_sample)) begin
        n_fail++;
        $display("FAIL tri_cycle%0d: got v=%0b w=%0b s=%0d, want v=%0b w=%0b s=%0d",
                 cyc, sample_valid, wrap, sample, exp_valid, exp_wrap, exp_sample);
      end
      if (sample_valid && int'(sample) > peak) peak = int'(sample);
    end
    n_checks++;
    if (peak != 2047) begin
      n_fail++;
      $display("FAIL tri_peak: got %0d, want 2047", peak);
    end
  endtask

  task automatic test_midperiod_load();
    int q[$];
    int wq[$];
    int guard = 0;
    int wi = -1;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 256, 0);
    while (!(m_phase == 1024 && m_div == 0) && guard < 100) begin
      cycle(1, 1, 0, 0, 0);
      guard++;
    end
    n_checks++;
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL midload_reach: phase 1024 not reached in %0d cycles", guard);
    end
    cycle(1, 1, 1, 512, 0);
    repeat (DIV * 16) begin
      cycle(1, 1, 0, 0, 0);
      n_checks++;
      if (sample_valid !== exp_valid || wrap !== exp_wrap || sample !== SW'(exp_sample)) begin
        n_fail++;
        $display("FAIL midload_cycle%0d: got v=%0b w=%0b s=%0d, want v=%0b w=%0b s=%0d",
                 cyc, sample_valid, wrap, sample, exp_valid, exp_wrap, exp_sample);
      end
      if (sample_valid) begin
        q.push_back(int'(sample));
        wq.push_back(int'(wrap));
        if (wrap && wi < 0) wi = q.size() - 1;
      end
    end
    n_checks++;
    if (wi < 1 || wi + 2 >= q.size()) begin
      n_fail++;
      $display("FAIL midload_wrap: wrap index %0d of %0d samples, want a wrap mid-run", wi, q.size());
    end else begin
      n_checks++;
      if (q[wi-1] != 1920 || q[wi] != 0 || q[wi+1] != 256 || q[wi+2] != 512) begin
        n_fail++;
        $display("FAIL midload_steps: got %0d,%0d,%0d,%0d, want 1920,0,256,512",
                 q[wi-1], q[wi], q[wi+1], q[wi+2]);
      end
    end
  endtask

  task automatic test_coincident_load();
    int q[$];
    int want[8] = '{512, 1024, 1536, 0, 256, 512, 768, 1024};
    int guard = 0;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 256, 0);
    while (m_fcur != 256 && guard < 20) begin
      cycle(1, 1, 0, 0, 0);
      guard++;
    end
    cycle(1, 1, 1, 1024, 0);
    while (!wrap_next() && guard < 120) begin
      cycle(1, 1, 0, 0, 0);
      guard++;
    end
    n_checks++;
    if (guard >= 120) begin
      n_fail++;
      $display("FAIL coinc_reach: apply tick not reached, guard %0d", guard);
    end
    cycle(1, 1, 1, 512, 0);
    n_checks++;
    if (wrap !== 1'b1 || sample_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL coinc_apply_tick: got v=%0b w=%0b, want v=1 w=1", sample_valid, wrap);
    end
    repeat (DIV * 8) begin
      cycle(1, 1, 0, 0, 0);
      if (sample_valid) q.push_back(int'(sample));
    end
    n_checks++;
    if (q.size() != 8) begin
      n_fail++;
      $display("FAIL coinc_count: got %0d, want 8", q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (q[k] != want[k]) begin
          n_fail++;
          $display("FAIL coinc_seq[%0d]: got %0d, want %0d", k, q[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_ena_hold();
    int last_v = 0;
    int new_v = -1;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 256, 0);
    repeat (13) begin
      cycle(1, 1, 0, 0, 0);
      if (sample_valid) last_v = cyc;
    end
    repeat (10) begin
      cycle(1, 0, 0, 0, 0);
      n_checks++;
      if (sample_valid !== 1'b0 || sample !== SW'(256)) begin
        n_fail++;
        $display("FAIL ena_hold: got v=%0b s=%0d, want v=0 s=256", sample_valid, sample);
      end
    end
    for (int i = 0; i < 8 && new_v < 0; i++) begin
      cycle(1, 1, 0, 0, 0);
      if (sample_valid) new_v = cyc;
    end
    n_checks++;
    if (new_v < 0 || new_v - last_v != DIV + 10 || sample !== SW'(384)) begin
      n_fail++;
      $display("FAIL ena_resume: got gap %0d s=%0d, want gap %0d s=384",
               (new_v < 0) ? -1 : new_v - last_v, sample, DIV + 10);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 256, 0);
    repeat (21) cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 512, 0);
    cycle(0, 1, 0, 0, 0);
    n_checks++;
    if (sample !== '0 || sample_valid !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state: got s=%0d v=%0b w=%0b, want 0 0 0", sample, sample_valid, wrap);
    end
    repeat (DIV * 4) begin
      cycle(1, 1, 0, 0, 0);
      if (sample_valid) begin
        nv++;
        n_checks++;
        if (sample !== '0 || wrap !== 1'b0) begin
          n_fail++;
          $display("FAIL rstmid_static: got s=%0d w=%0b, want s=0 w=0", sample, wrap);
        end
      end
    end
    n_checks++;
    if (nv != 4) begin
      n_fail++;
      $display("FAIL rstmid_pulses: got %0d, want 4", nv);
    end
  endtask

  task automatic test_random();
    cycle(0, 0, 0, 0, 0);
    repeat (3000) begin
      bit r, e, ld;
      int w, s;
      r  = ($urandom_range(0, 299) != 0);
      e  = ($urandom_range(0, 7) != 0);
      ld = ($urandom_range(0, 19) == 0);
      w  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PMOD - 1) : $urandom_range(0, 15) * 64;
      s  = $urandom_range(0, 3);
      cycle(r, e, ld, w, s);
      n_checks++;
      if (sample_valid !== exp_valid || wrap !== exp_wrap || sample !== SW'(exp_sample)) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got v=%0b w=%0b s=%0d, want v=%0b w=%0b s=%0d",
                 cyc, sample_valid, wrap, sample, exp_valid, exp_wrap, exp_sample);
      end
    end
  endtask

  initial begin
    test_reset();
    test_saw();
    test_square_tri();
    test_midperiod_load();
    test_coincident_load();
    test_ena_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
